// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle between the UART receiver and its consumer:
// the one-entry byte buffer, its valid/ready pair, and the two error pulses.
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 frame_err;
   logic                 overrun_err;

   modport master (
      output rx_data,
      output rx_valid,
      output frame_err,
      output overrun_err,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  overrun_err,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling from the shared baud divisor,
// a one-entry output buffer and single-cycle framing/overrun error pulses.
module uart_rx #(
   parameter int DATA_BITS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] brd,
   input  logic        rx_in,
   output logic        busy,
   uart_rx_if.master   rx
);

   localparam int BI_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [BI_W-1:0] LAST_BIT = BI_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   rx_state_t            state, state_n;
   logic                 sync_a, rxs;
   logic [15:0]          tcnt, tcnt_n;
   logic [15:0]          t_div, t_period;
   logic                 tick;
   logic [3:0]           os, os_n;
   logic [BI_W-1:0]      bi, bi_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic [DATA_BITS:0]   shift_in;
   logic                 stop_good, stop_good_n;
   logic                 stop_bad, stop_bad_n;

   // Two-flop synchronizer; resetting to the idle level means a line that is
   // still low after reset is seen as a fresh falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_a <= 1'b1;
         rxs    <= 1'b1;
      end else begin
         sync_a <= rx_in;
         rxs    <= sync_a;
      end
   end

   assign t_div    = {4'd0, brd[15:4]};
   assign t_period = (t_div == 16'd0) ? 16'd1 : t_div;
   assign tick     = (tcnt == (t_period - 16'd1));
   assign shift_in = {rxs, shreg};
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         tcnt      <= 16'd0;
         os        <= 4'd0;
         bi        <= '0;
         shreg     <= '0;
         stop_good <= 1'b0;
         stop_bad  <= 1'b0;
      end else begin
         state     <= state_n;
         tcnt      <= tcnt_n;
         os        <= os_n;
         bi        <= bi_n;
         shreg     <= shreg_n;
         stop_good <= stop_good_n;
         stop_bad  <= stop_bad_n;
      end
   end

   // Oversample phase 7 is mid start bit; phase 15 is mid data/stop bit,
   // because the phase counter restarts at the start-bit midpoint.
   always_comb begin
      state_n     = state;
      tcnt_n      = tick ? 16'd0 : (tcnt + 16'd1);
      os_n        = os;
      bi_n        = bi;
      shreg_n     = shreg;
      stop_good_n = 1'b0;
      stop_bad_n  = 1'b0;

      if (tick && (state != IDLE)) begin
         os_n = os + 4'd1;
      end

      case (state)
         IDLE: begin
            if (!rxs) begin
               state_n = START;
               os_n    = 4'd0;
               tcnt_n  = 16'd0;
            end
         end
         START: begin
            if (tick && (os == 4'd7)) begin
               if (!rxs) begin
                  state_n = DATA;
                  os_n    = 4'd0;
                  bi_n    = '0;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DATA: begin
            if (tick && (os == 4'd15)) begin
               shreg_n = shift_in[DATA_BITS:1];
               bi_n    = bi + 1'b1;
               if (bi == LAST_BIT) begin
                  state_n = STOP;
                  os_n    = 4'd0;
               end
            end
         end
         STOP: begin
            if (tick && (os == 4'd15)) begin
               stop_good_n = rxs;
               stop_bad_n  = !rxs;
               state_n     = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Output buffer acts one clock after the stop sample; a consumer handshake
   // in that same cycle frees the slot, so the new byte replaces the old one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx.rx_data     <= '0;
         rx.rx_valid    <= 1'b0;
         rx.frame_err   <= 1'b0;
         rx.overrun_err <= 1'b0;
      end else begin
         rx.frame_err   <= stop_bad;
         rx.overrun_err <= 1'b0;
         if (stop_good) begin
            if (!rx.rx_valid || rx.rx_ready) begin
               rx.rx_data  <= shreg;
               rx.rx_valid <= 1'b1;
            end else begin
               rx.overrun_err <= 1'b1;
            end
         end else if (rx.rx_valid && rx.rx_ready) begin
            rx.rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// checked against a behavioural model of the receive buffer and frame timing.
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] brd;
   logic        rx_in;
   logic        busy;

   uart_rx_if #(.DATA_BITS(8)) rx_if ();

   uart_rx #(.DATA_BITS(8)) dut (
      .clk   (clk),
      .reset (reset),
      .brd   (brd),
      .rx_in (rx_in),
      .busy  (busy),
      .rx    (rx_if)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int fe_cnt       = 0;
   int ov_cnt       = 0;
   int vr_cnt       = 0;
   int vr_cyc       = 0;
   int br_cyc       = 0;
   int bf_cyc       = 0;
   logic prev_v     = 1'b0;
   logic prev_b     = 1'b0;
   logic [7:0] last_good = 8'h00;

   always @(posedge clk) cyc++;

   // Event monitor sampled away from the active edge.
   always @(negedge clk) begin
      if (rx_if.frame_err === 1'b1) fe_cnt++;
      if (rx_if.overrun_err === 1'b1) ov_cnt++;
      if (rx_if.rx_valid === 1'b1 && prev_v !== 1'b1) begin
         vr_cnt++;
         vr_cyc = cyc;
      end
      if (busy === 1'b1 && prev_b !== 1'b1) br_cyc = cyc;
      if (busy === 1'b0 && prev_b === 1'b1) bf_cyc = cyc;
      prev_v = rx_if.rx_valid;
      prev_b = busy;
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic send_frame(input logic [7:0] b, input logic stop, input int bitclk);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_in = bits[i];
         repeat (bitclk) @(negedge clk);
      end
      rx_in = 1'b1;
   endtask

   task automatic wait_busy(input logic level, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (busy === level) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic settle();
      bit ok;
      rx_in = 1'b1;
      wait_busy(1'b0, 4000, ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("[TB] FAIL settle_idle: busy=%b, required 0 within 4000 cycles", busy);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic consume();
      if (rx_if.rx_valid === 1'b1) begin
         rx_if.rx_ready = 1'b1;
         @(negedge clk);
         rx_if.rx_ready = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rx_in = 1'b1;
      brd   = 16'd64;
      rx_if.rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({rx_if.rx_valid, rx_if.frame_err, rx_if.overrun_err, busy} !== 4'b0000 ||
          rx_if.rx_data !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: valid=%b fe=%b ov=%b busy=%b data=%h, required all 0",
                  rx_if.rx_valid, rx_if.frame_err, rx_if.overrun_err, busy, rx_if.rx_data);
      end
      reset = 1'b0;
      repeat (4) @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL idle_after_reset: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_good_byte();
      int v0;
      v0  = vr_cnt;
      brd = 16'd64;
      send_frame(8'hA5, 1'b1, 64);
      settle();
      tests_run++;
      if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'hA5 || vr_cnt != v0 + 1) begin
         tests_failed++;
         $display("[TB] FAIL good_byte: valid=%b data=%h rises=%0d, required 1 a5 %0d",
                  rx_if.rx_valid, rx_if.rx_data, vr_cnt - v0, 1);
      end
      tests_run++;
      if (vr_cyc - br_cyc != 152 * 4 + 1) begin
         tests_failed++;
         $display("[TB] FAIL good_byte_latency: %0d clocks, required %0d", vr_cyc - br_cyc, 152 * 4 + 1);
      end
      rx_if.rx_ready = 1'b1;
      @(negedge clk);
      rx_if.rx_ready = 1'b0;
      tests_run++;
      if (rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'hA5) begin
         tests_failed++;
         $display("[TB] FAIL consume: valid=%b data=%h, required 0 a5", rx_if.rx_valid, rx_if.rx_data);
      end
      last_good = 8'hA5;
   endtask

   task automatic test_false_start();
      int v0, f0, b0;
      bit ok;
      v0 = vr_cnt;
      f0 = fe_cnt;
      b0 = br_cyc;
      brd = 16'd64;
      rx_in = 1'b0;
      repeat (12) @(negedge clk);
      rx_in = 1'b1;
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL false_start_detect: busy=%b, required 1", busy);
      end
      wait_busy(1'b0, 60, ok);
      repeat (2) @(negedge clk);
      tests_run++;
      if (!ok || br_cyc == b0 || bf_cyc - br_cyc != 8 * 4) begin
         tests_failed++;
         $display("[TB] FAIL false_start_abort: ok=%b busy_len=%0d, required 1 %0d", ok, bf_cyc - br_cyc, 32);
      end
      tests_run++;
      if (vr_cnt != v0 || fe_cnt != f0 || rx_if.rx_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL false_start_quiet: valid_rises=%0d fe=%0d, required 0 0", vr_cnt - v0, fe_cnt - f0);
      end
      settle();
   endtask

   task automatic test_frame_err();
      int v0, f0, o0;
      v0 = vr_cnt;
      f0 = fe_cnt;
      o0 = ov_cnt;
      send_frame(8'h3C, 1'b0, 64);
      settle();
      tests_run++;
      if (fe_cnt != f0 + 1) begin
         tests_failed++;
         $display("[TB] FAIL frame_err_pulse: %0d cycles high, required 1", fe_cnt - f0);
      end
      tests_run++;
      if (rx_if.rx_valid !== 1'b0 || vr_cnt != v0 || ov_cnt != o0 || rx_if.rx_data !== last_good) begin
         tests_failed++;
         $display("[TB] FAIL frame_err_discard: valid=%b data=%h ov=%0d, required 0 %h 0",
                  rx_if.rx_valid, rx_if.rx_data, ov_cnt - o0, last_good);
      end
   endtask

   task automatic test_overrun();
      int v0, o0;
      bit ok1, ok2, ok3;
      consume();
      v0 = vr_cnt;
      o0 = ov_cnt;
      send_frame(8'h11, 1'b1, 64);
      send_frame(8'h22, 1'b1, 64);
      settle();
      tests_run++;
      if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h11 || vr_cnt != v0 + 1) begin
         tests_failed++;
         $display("[TB] FAIL overrun_keep: valid=%b data=%h rises=%0d, required 1 11 1",
                  rx_if.rx_valid, rx_if.rx_data, vr_cnt - v0);
      end
      tests_run++;
      if (ov_cnt != o0 + 1) begin
         tests_failed++;
         $display("[TB] FAIL overrun_pulse: %0d cycles high, required 1", ov_cnt - o0);
      end

      consume();
      v0 = vr_cnt;
      o0 = ov_cnt;
      fork
         begin
            send_frame(8'h11, 1'b1, 64);
            send_frame(8'h22, 1'b1, 64);
         end
         begin
            wait_busy(1'b1, 2000, ok1);
            wait_busy(1'b0, 2000, ok2);
            wait_busy(1'b1, 2000, ok3);
            repeat (152 * 4) @(negedge clk);
            rx_if.rx_ready = 1'b1;
            @(negedge clk);
            rx_if.rx_ready = 1'b0;
         end
      join
      settle();
      tests_run++;
      if (!(ok1 && ok2 && ok3) || rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h22 || ov_cnt != o0) begin
         tests_failed++;
         $display("[TB] FAIL overrun_replace: waits=%b%b%b valid=%b data=%h ov=%0d, required 111 1 22 0",
                  ok1, ok2, ok3, rx_if.rx_valid, rx_if.rx_data, ov_cnt - o0);
      end
      last_good = 8'h22;
   endtask

   task automatic test_reset_mid_frame();
      fork
         send_frame(8'hFF, 1'b1, 64);
         begin
            repeat (64 * 4 + 32) @(negedge clk);
            tests_run++;
            if (busy !== 1'b1 || rx_if.rx_valid !== 1'b1) begin
               tests_failed++;
               $display("[TB] FAIL pre_reset_state: busy=%b valid=%b, required 1 1", busy, rx_if.rx_valid);
            end
            #2 reset = 1'b1;
            #1;
            tests_run++;
            if ({rx_if.rx_valid, rx_if.frame_err, rx_if.overrun_err, busy} !== 4'b0000 ||
                rx_if.rx_data !== 8'h00) begin
               tests_failed++;
               $display("[TB] FAIL async_reset: valid=%b fe=%b ov=%b busy=%b data=%h, required all 0",
                        rx_if.rx_valid, rx_if.frame_err, rx_if.overrun_err, busy, rx_if.rx_data);
            end
            repeat (3) @(negedge clk);
            reset = 1'b0;
         end
      join
      settle();
      send_frame(8'h5A, 1'b1, 64);
      settle();
      tests_run++;
      if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h5A) begin
         tests_failed++;
         $display("[TB] FAIL post_reset_frame: valid=%b data=%h, required 1 5a", rx_if.rx_valid, rx_if.rx_data);
      end
      consume();
      last_good = 8'h5A;
   endtask

   task automatic test_min_divisor();
      brd = 16'd15;
      send_frame(8'h81, 1'b1, 16);
      settle();
      tests_run++;
      if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h81 || vr_cyc - br_cyc != 153) begin
         tests_failed++;
         $display("[TB] FAIL min_divisor: valid=%b data=%h latency=%0d, required 1 81 153",
                  rx_if.rx_valid, rx_if.rx_data, vr_cyc - br_cyc);
      end
      consume();
      last_good = 8'h81;
   endtask

   task automatic test_random();
      int t, v0, f0, o0;
      logic [7:0] b;
      bit bad;
      for (int n = 0; n < 10; n++) begin
         t   = $urandom_range(1, 6);
         brd = (t == 1) ? 16'($urandom_range(0, 31)) : 16'(16 * t + $urandom_range(0, 15));
         b   = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 3) == 0);
         v0 = vr_cnt;
         f0 = fe_cnt;
         o0 = ov_cnt;
         send_frame(b, !bad, 16 * t);
         settle();
         if (bad) begin
            tests_run++;
            if (fe_cnt != f0 + 1 || rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== last_good) begin
               tests_failed++;
               $display("[TB] FAIL rand_bad_%0d: fe=%0d valid=%b data=%h, required 1 0 %h",
                        n, fe_cnt - f0, rx_if.rx_valid, rx_if.rx_data, last_good);
            end
         end else begin
            tests_run++;
            if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== b || vr_cnt != v0 + 1 ||
                vr_cyc - br_cyc != 152 * t + 1 || fe_cnt != f0 || ov_cnt != o0) begin
               tests_failed++;
               $display("[TB] FAIL rand_good_%0d: valid=%b data=%h latency=%0d, required 1 %h %0d",
                        n, rx_if.rx_valid, rx_if.rx_data, vr_cyc - br_cyc, b, 152 * t + 1);
            end
            consume();
            last_good = b;
         end
      end
   endtask

   initial begin
      test_reset();
      test_good_byte();
      test_false_start();
      test_frame_err();
      test_overrun();
      test_reset_mid_frame();
      test_min_divisor();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
